// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int BLOCK_WORDS      = 16;
    localparam int NIBBLES_PER_WORD = 8;
    localparam int MAX_1BLK_NIBBLES = 111;
    localparam int N_W              = 8;

    typedef enum logic [1:0] {
        IDLE,
        EMIT0,
        EMIT1
    } pad_state_e;

    // A message needs a second block once '1' plus the 64-bit length no longer fit.
    function automatic logic needs_two_blocks(input logic [N_W-1:0] n);
        return n > N_W'(MAX_1BLK_NIBBLES);
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational generator for one padded 32-bit word at a given block/word position.
module sha256_pad_word
    import sha256_pkg::*;
#(
    parameter int MSG_NIBBLES = 128
) (
    input  logic [MSG_NIBBLES-1:0][3:0] mess,
    input  logic [N_W-1:0]              n,
    input  logic                        blk,
    input  logic [3:0]                  idx,
    input  logic                        final_blk,
    output word_t                       word
);

    logic [255:0][3:0] ext;
    logic [7:0]        g;

    // Nibble g of the padded stream is message, the '1' marker, or zero fill.
    always_comb begin
        ext                    = '0;
        ext[MSG_NIBBLES-1:0]   = mess;
        word                   = '0;
        g                      = '0;
        for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
            g = {blk, idx, 3'(k)};
            if (g < n) begin
                word[31-4*k -: 4] = ext[g];
            end else if (g == n) begin
                word[31-4*k -: 4] = 4'h8;
            end
        end
        if (final_blk && idx == 4'(BLOCK_WORDS - 2)) begin
            word = '0;
        end else if (final_blk && idx == 4'(BLOCK_WORDS - 1)) begin
            word = {22'b0, n, 2'b00};
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 padder: captures a nibble-packed message and streams its padded 512-bit blocks as words.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int MSG_NIBBLES = 128,
    parameter int LEN_W       = $clog2(MSG_NIBBLES*4+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MSG_NIBBLES-1:0][3:0] mess,
    input  logic [LEN_W-1:0]            msg_len,
    output logic                        out_valid,
    input  logic                        out_ready,
    output word_t                       out_word,
    output logic [3:0]                  out_idx,
    output logic                        out_last_word,
    output logic                        out_last_block,
    output logic                        len_err
);

    localparam int CAP_BITS = MSG_NIBBLES * 4;

    pad_state_e                  state_q, state_d;
    logic [MSG_NIBBLES-1:0][3:0] mess_q, mess_d;
    logic [N_W-1:0]              n_q, n_d;
    logic                        two_q, two_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    word_t                       out_word_q, out_word_d;
    logic [3:0]                  out_idx_q, out_idx_d;
    logic                        out_last_word_q, out_last_word_d;
    logic                        out_last_block_q, out_last_block_d;
    logic                        len_err_q, len_err_d;

    logic                        accept, hs, bad_len, two_in;
    logic [LEN_W-1:0]            clipped;
    logic [N_W-1:0]              n_in;
    logic [MSG_NIBBLES-1:0][3:0] pw_mess;
    logic [N_W-1:0]              pw_n;
    logic                        pw_blk, pw_final;
    logic [3:0]                  pw_idx;
    word_t                       pw_word;

    // The word generator looks one position ahead; on accept it reads the live inputs.
    always_comb begin
        accept  = in_valid && in_ready_q;
        hs      = out_valid_q && out_ready;
        bad_len = (msg_len > LEN_W'(CAP_BITS)) || (msg_len[1:0] != 2'b00);
        clipped = (msg_len > LEN_W'(CAP_BITS)) ? LEN_W'(CAP_BITS) : msg_len;
        n_in    = N_W'(clipped >> 2);
        two_in  = needs_two_blocks(n_in);
        if (accept) begin
            pw_mess  = mess;
            pw_n     = n_in;
            pw_blk   = 1'b0;
            pw_idx   = 4'd0;
            pw_final = !two_in;
        end else begin
            pw_mess = mess_q;
            pw_n    = n_q;
            if (out_idx_q == 4'd15) begin
                pw_blk = 1'b1;
                pw_idx = 4'd0;
            end else begin
                pw_blk = (state_q == EMIT1);
                pw_idx = 4'(out_idx_q + 4'd1);
            end
            pw_final = pw_blk || !two_q;
        end
    end

    sha256_pad_word #(.MSG_NIBBLES(MSG_NIBBLES)) u_pad_word (
        .mess      (pw_mess),
        .n         (pw_n),
        .blk       (pw_blk),
        .idx       (pw_idx),
        .final_blk (pw_final),
        .word      (pw_word)
    );

    always_comb begin
        state_d          = state_q;
        mess_d           = mess_q;
        n_d              = n_q;
        two_d            = two_q;
        in_ready_d       = in_ready_q;
        out_valid_d      = out_valid_q;
        out_word_d       = out_word_q;
        out_idx_d        = out_idx_q;
        out_last_word_d  = out_last_word_q;
        out_last_block_d = out_last_block_q;
        len_err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mess_d           = mess;
                    n_d              = n_in;
                    two_d            = two_in;
                    len_err_d        = bad_len;
                    in_ready_d       = 1'b0;
                    out_valid_d      = 1'b1;
                    out_word_d       = pw_word;
                    out_idx_d        = 4'd0;
                    out_last_word_d  = 1'b0;
                    out_last_block_d = !two_in;
                    state_d          = EMIT0;
                end
            end
            EMIT0, EMIT1: begin
                if (hs) begin
                    if (out_idx_q == 4'd15) begin
                        if (state_q == EMIT0 && two_q) begin
                            state_d          = EMIT1;
                            out_word_d       = pw_word;
                            out_idx_d        = 4'd0;
                            out_last_word_d  = 1'b0;
                            out_last_block_d = 1'b1;
                        end else begin
                            state_d          = IDLE;
                            in_ready_d       = 1'b1;
                            out_valid_d      = 1'b0;
                            out_word_d       = '0;
                            out_idx_d        = 4'd0;
                            out_last_word_d  = 1'b0;
                            out_last_block_d = 1'b0;
                        end
                    end else begin
                        out_word_d      = pw_word;
                        out_idx_d       = 4'(out_idx_q + 4'd1);
                        out_last_word_d = (out_idx_q == 4'd14);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            mess_q           <= '0;
            n_q              <= '0;
            two_q            <= 1'b0;
            in_ready_q       <= 1'b1;
            out_valid_q      <= 1'b0;
            out_word_q       <= '0;
            out_idx_q        <= 4'd0;
            out_last_word_q  <= 1'b0;
            out_last_block_q <= 1'b0;
            len_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            mess_q           <= mess_d;
            n_q              <= n_d;
            two_q            <= two_d;
            in_ready_q       <= in_ready_d;
            out_valid_q      <= out_valid_d;
            out_word_q       <= out_word_d;
            out_idx_q        <= out_idx_d;
            out_last_word_q  <= out_last_word_d;
            out_last_block_q <= out_last_block_d;
            len_err_q        <= len_err_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_word       = out_word_q;
    assign out_idx        = out_idx_q;
    assign out_last_word  = out_last_word_q;
    assign out_last_block = out_last_block_q;
    assign len_err        = len_err_q;

endmodule
